user_pos_ctrl: RTL and testbench

Frame-synchronous position controller for the player sprite in the labyrinth display pipeline. Once per movement frame it samples the direction keys and computes a candidate position, clamped to the screen. It asks the maze collision checker whether that position is free and commits it only on a non-colliding answer. Its `x_pos`/`y_pos` outputs drive the sprite-drawing stage directly, and they change only during vertical blanking.

---
 rtl/user_pos_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_user_pos_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/user_pos_ctrl.sv
// Player sprite position controller: once per movement frame it proposes a step
// from the direction keys, queries the maze collision checker, and commits on a clear answer.
module user_pos_ctrl #(
    parameter int X_START     = 100,
    parameter int Y_START     = 100,
    parameter int STEP        = 4,
    parameter int FRAME_DIV   = 2,
    parameter int USER_W      = 100,
    parameter int USER_H      = 100,
    parameter int SCREEN_W    = 800,
    parameter int SCREEN_H    = 600,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblank_in,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        chk_ack,
    input  logic        chk_hit,
    output logic        chk_req,
    output logic [11:0] chk_x,
    output logic [11:0] chk_y,
    output logic [11:0] x_pos,
    output logic [11:0] y_pos,
    output logic        moved,
    output logic        busy
);

    localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_DIV - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [12:0]     STEP_V  = 13'(STEP);
    localparam logic [12:0]     X_MAX   = 13'(SCREEN_W - USER_W);
    localparam logic [12:0]     Y_MAX   = 13'(SCREEN_H - USER_H);
    localparam logic [11:0]     X_RST   = 12'(X_START);
    localparam logic [11:0]     Y_RST   = 12'(Y_START);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECIDE = 2'd1,
        S_CHECK  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              vblank_d_q, vblank_d_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [11:0]       x_pos_q, x_pos_d;
    logic [11:0]       y_pos_q, y_pos_d;
    logic              chk_req_q, chk_req_d;
    logic [11:0]       chk_x_q, chk_x_d;
    logic [11:0]       chk_y_q, chk_y_d;
    logic              moved_q, moved_d;
    logic              busy_q, busy_d;

    logic              tick;
    logic              key_any;
    logic [12:0]       x_cur, y_cur;
    logic [12:0]       up_y, dn_y, lf_x, rt_x;
    logic [12:0]       cand_x, cand_y;

    assign tick    = vblank_in & ~vblank_d_q;
    assign key_any = key_up | key_down | key_left | key_right;
    assign x_cur   = {1'b0, x_pos_q};
    assign y_cur   = {1'b0, y_pos_q};

    // Saturating candidate for each direction; only one axis moves, chosen by key priority.
    always_comb begin
        up_y   = (y_cur < STEP_V) ? 13'd0 : (y_cur - STEP_V);
        dn_y   = ((y_cur + STEP_V) > Y_MAX) ? Y_MAX : (y_cur + STEP_V);
        lf_x   = (x_cur < STEP_V) ? 13'd0 : (x_cur - STEP_V);
        rt_x   = ((x_cur + STEP_V) > X_MAX) ? X_MAX : (x_cur + STEP_V);
        cand_x = x_cur;
        cand_y = y_cur;
        if (key_up) begin
            cand_y = up_y;
        end else if (key_down) begin
            cand_y = dn_y;
        end else if (key_left) begin
            cand_x = lf_x;
        end else if (key_right) begin
            cand_x = rt_x;
        end else begin
            cand_x = x_cur;
            cand_y = y_cur;
        end
    end

    // Next-state logic: frame divider, decide, collision handshake with timeout.
    always_comb begin
        state_d     = state_q;
        vblank_d_d  = vblank_in;
        frame_cnt_d = frame_cnt_q;
        to_cnt_d    = to_cnt_q;
        x_pos_d     = x_pos_q;
        y_pos_d     = y_pos_q;
        chk_req_d   = chk_req_q;
        chk_x_d     = chk_x_q;
        chk_y_d     = chk_y_q;
        moved_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                chk_req_d = 1'b0;
                if (tick) begin
                    if (frame_cnt_q == FC_LAST) begin
                        frame_cnt_d = {FC_W{1'b0}};
                        state_d     = S_DECIDE;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FC_W'(1);
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end
            S_DECIDE: begin
                // Nothing pressed or pinned at the border: skip the query entirely.
                if (!key_any || ((cand_x == x_cur) && (cand_y == y_cur))) begin
                    state_d = S_IDLE;
                end else begin
                    chk_x_d   = cand_x[11:0];
                    chk_y_d   = cand_y[11:0];
                    chk_req_d = 1'b1;
                    to_cnt_d  = {TO_W{1'b0}};
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (chk_ack) begin
                    chk_req_d = 1'b0;
                    state_d   = S_IDLE;
                    if (!chk_hit) begin
                        x_pos_d = chk_x_q;
                        y_pos_d = chk_y_q;
                        moved_d = 1'b1;
                    end else begin
                        x_pos_d = x_pos_q;
                        y_pos_d = y_pos_q;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    chk_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: begin
                chk_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset asynchronously drops any query in flight.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            vblank_d_q  <= 1'b0;
            frame_cnt_q <= {FC_W{1'b0}};
            to_cnt_q    <= {TO_W{1'b0}};
            x_pos_q     <= X_RST;
            y_pos_q     <= Y_RST;
            chk_req_q   <= 1'b0;
            chk_x_q     <= 12'd0;
            chk_y_q     <= 12'd0;
            moved_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vblank_d_q  <= vblank_d_d;
            frame_cnt_q <= frame_cnt_d;
            to_cnt_q    <= to_cnt_d;
            x_pos_q     <= x_pos_d;
            y_pos_q     <= y_pos_d;
            chk_req_q   <= chk_req_d;
            chk_x_q     <= chk_x_d;
            chk_y_q     <= chk_y_d;
            moved_q     <= moved_d;
            busy_q      <= busy_d;
        end
    end

    assign chk_req = chk_req_q;
    assign chk_x   = chk_x_q;
    assign chk_y   = chk_y_q;
    assign x_pos   = x_pos_q;
    assign y_pos   = y_pos_q;
    assign moved   = moved_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_user_pos_ctrl.sv
// Directed bench for user_pos_ctrl: three instances (main, clamp corner, frame divider)
// sharing clock, reset, vblank and keys, each with its own collision checker inputs.
module tb_user_pos_ctrl;

    logic pclk = 1'b0;
    logic rst, vblank;
    logic key_up, key_down, key_left, key_right;
    logic a_ack, a_hit, b_ack, b_hit, c_ack, c_hit;

    logic        a_req, b_req, c_req;
    logic [11:0] a_cx, a_cy, b_cx, b_cy, c_cx, c_cy;
    logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic        a_mv, b_mv, c_mv, a_busy, b_busy, c_busy;

    int errors = 0;
    int checks = 0;
    int q;
    int total;

    always #5 pclk = ~pclk;

    user_pos_ctrl #(.FRAME_DIV(1)) u_a (
        .pclk(pclk), .rst(rst), .vblank_in(vblank),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .chk_ack(a_ack), .chk_hit(a_hit), .chk_req(a_req), .chk_x(a_cx), .chk_y(a_cy),
        .x_pos(a_x), .y_pos(a_y), .moved(a_mv), .busy(a_busy)
    );

    user_pos_ctrl #(.FRAME_DIV(1), .X_START(698), .Y_START(2)) u_b (
        .pclk(pclk), .rst(rst), .vblank_in(vblank),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .chk_ack(b_ack), .chk_hit(b_hit), .chk_req(b_req), .chk_x(b_cx), .chk_y(b_cy),
        .x_pos(b_x), .y_pos(b_y), .moved(b_mv), .busy(b_busy)
    );

    user_pos_ctrl #(.FRAME_DIV(2)) u_c (
        .pclk(pclk), .rst(rst), .vblank_in(vblank),
        .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
        .chk_ack(c_ack), .chk_hit(c_hit), .chk_req(c_req), .chk_x(c_cx), .chk_y(c_cy),
        .x_pos(c_x), .y_pos(c_y), .moved(c_mv), .busy(c_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Leaves the caller in tick cycle T (vblank just rose).
    task automatic do_tick();
        vblank = 1'b0;
        step();
        step();
        vblank = 1'b1;
    endtask

    initial begin
        rst = 1'b1; vblank = 1'b0;
        key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
        a_ack = 1'b0; a_hit = 1'b0; b_ack = 1'b0; b_hit = 1'b0; c_ack = 1'b0; c_hit = 1'b0;
        repeat (3) step();
        check("rst_a_x", 32'(a_x), 32'd100);
        check("rst_a_y", 32'(a_y), 32'd100);
        check("rst_a_busy", 32'(a_busy), 32'd0);
        check("rst_a_req", 32'(a_req), 32'd0);
        check("rst_a_chk_x", 32'(a_cx), 32'd0);
        check("rst_a_moved", 32'(a_mv), 32'd0);
        check("rst_b_x", 32'(b_x), 32'd698);
        rst = 1'b0;
        step();

        // Right move with immediate clear ack; corner instance clamps to 700.
        key_right = 1'b1;
        do_tick();
        step();
        check("right_t1_busy", 32'(a_busy), 32'd1);
        check("right_t1_req", 32'(a_req), 32'd0);
        step();
        check("right_t2_req", 32'(a_req), 32'd1);
        check("right_chk_x", 32'(a_cx), 32'd104);
        check("right_chk_y", 32'(a_cy), 32'd100);
        check("right_x_early", 32'(a_x), 32'd100);
        check("clamp_chk_x", 32'(b_cx), 32'd700);
        check("clamp_chk_y", 32'(b_cy), 32'd2);
        check("div_tick1_req", 32'(c_req), 32'd0);
        check("div_tick1_busy", 32'(c_busy), 32'd0);
        a_ack = 1'b1; b_ack = 1'b1;
        step();
        check("right_x_commit", 32'(a_x), 32'd104);
        check("right_moved", 32'(a_mv), 32'd1);
        check("right_req_drop", 32'(a_req), 32'd0);
        check("right_busy_drop", 32'(a_busy), 32'd0);
        check("clamp_x_commit", 32'(b_x), 32'd700);
        check("clamp_moved", 32'(b_mv), 32'd1);
        a_ack = 1'b0; b_ack = 1'b0;
        step();
        check("right_moved_pulse", 32'(a_mv), 32'd0);

        // Right again: corner is pinned (no query); main instance gets no ack and times out.
        do_tick();
        step();
        check("pinned_t1_busy", 32'(b_busy), 32'd1);
        step();
        check("pinned_req", 32'(b_req), 32'd0);
        check("pinned_busy", 32'(b_busy), 32'd0);
        q = 0;
        repeat (40) begin
            if (a_req) q++;
            step();
        end
        check("timeout_req_cycles", 32'(q), 32'd15);
        check("timeout_busy", 32'(a_busy), 32'd0);
        check("timeout_x", 32'(a_x), 32'd104);
        a_ack = 1'b1;
        step();
        step();
        check("late_ack_req", 32'(a_req), 32'd0);
        check("late_ack_moved", 32'(a_mv), 32'd0);
        check("late_ack_x", 32'(a_x), 32'd104);
        a_ack = 1'b0;

        // Up: main collides, corner saturates y to 0 and commits.
        key_right = 1'b0; key_up = 1'b1;
        do_tick();
        step();
        step();
        check("up_req", 32'(a_req), 32'd1);
        check("up_chk_x", 32'(a_cx), 32'd104);
        check("up_chk_y", 32'(a_cy), 32'd96);
        check("sat_chk_x", 32'(b_cx), 32'd700);
        check("sat_chk_y", 32'(b_cy), 32'd0);
        a_ack = 1'b1; a_hit = 1'b1; b_ack = 1'b1; b_hit = 1'b0;
        step();
        check("hit_y", 32'(a_y), 32'd100);
        check("hit_moved", 32'(a_mv), 32'd0);
        check("hit_req_drop", 32'(a_req), 32'd0);
        check("sat_y_commit", 32'(b_y), 32'd0);
        check("sat_moved", 32'(b_mv), 32'd1);
        a_ack = 1'b0; a_hit = 1'b0; b_ack = 1'b0;

        // Up+left: up wins; ack arrives in the last allowed CHECK cycle.
        key_left = 1'b1;
        do_tick();
        step();
        step();
        check("prio_chk_x", 32'(a_cx), 32'd104);
        check("prio_chk_y", 32'(a_cy), 32'd96);
        check("top_pinned_req", 32'(b_req), 32'd0);
        check("top_pinned_busy", 32'(b_busy), 32'd0);
        repeat (14) step();
        check("last_cycle_req", 32'(a_req), 32'd1);
        check("last_cycle_chk_y", 32'(a_cy), 32'd96);
        a_ack = 1'b1;
        step();
        check("edge_ack_y", 32'(a_y), 32'd96);
        check("edge_ack_x", 32'(a_x), 32'd104);
        check("edge_ack_moved", 32'(a_mv), 32'd1);
        check("edge_ack_req", 32'(a_req), 32'd0);
        a_ack = 1'b0;
        step();
        check("edge_moved_pulse", 32'(a_mv), 32'd0);

        // Asynchronous reset in the middle of a query.
        key_up = 1'b0; key_left = 1'b0; key_down = 1'b1;
        do_tick();
        step();
        step();
        check("down_req", 32'(a_req), 32'd1);
        check("down_chk_y", 32'(a_cy), 32'd100);
        #3;
        rst = 1'b1; vblank = 1'b0;
        #1;
        check("async_rst_req", 32'(a_req), 32'd0);
        check("async_rst_x", 32'(a_x), 32'd100);
        check("async_rst_y", 32'(a_y), 32'd100);
        check("async_rst_busy", 32'(a_busy), 32'd0);
        @(posedge pclk);
        #1;
        step();
        rst = 1'b0;
        key_down = 1'b0; key_left = 1'b1;
        step();

        // Divider: query only on even ticks after reset, immediate hit answers.
        c_ack = 1'b1; c_hit = 1'b1;
        total = 0;
        for (int n = 1; n <= 6; n++) begin
            do_tick();
            q = 0;
            repeat (6) begin
                step();
                if (c_req) q++;
            end
            check($sformatf("div_tick%0d", n), 32'(q), ((n % 2) == 0) ? 32'd1 : 32'd0);
            total += q;
        end
        check("div_total", 32'(total), 32'd3);
        check("div_x", 32'(c_x), 32'd100);

        // Tick arriving while in CHECK must be dropped.
        c_ack = 1'b0;
        do_tick();
        repeat (6) step();
        do_tick();
        step();
        step();
        check("drop_in_check", 32'(c_req), 32'd1);
        vblank = 1'b0;
        step();
        vblank = 1'b1;
        check("drop_still_check", 32'(c_req), 32'd1);
        step();
        step();
        c_ack = 1'b1;
        step();
        check("drop_req_done", 32'(c_req), 32'd0);
        check("drop_busy_done", 32'(c_busy), 32'd0);
        repeat (3) step();
        do_tick();
        q = 0;
        repeat (6) begin
            step();
            if (c_req) q++;
        end
        check("after_drop_tick_a", 32'(q), 32'd0);
        do_tick();
        q = 0;
        repeat (6) begin
            step();
            if (c_req) q++;
        end
        check("after_drop_tick_b", 32'(q), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
